// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        LOAD,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the loader.
// A byte moves on a rising edge where in_valid and in_ready are both high; the source holds
// in_data stable while in_valid is high, and in_valid is ignored while in_ready is low.
interface imem_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four consecutive bytes into a little-endian 32-bit word.
// word_valid pulses in the same cycle as the 4th byte; word is valid alongside it.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [31:0] shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lane  <= 2'd0;
            shreg <= 32'd0;
        end else if (byte_valid) begin
            lane  <= lane + 2'd1;
            shreg <= {byte_data, shreg[31:8]};
        end
    end

    // The newest byte lands in the top lane, so byte 0 ends up in bits [7:0].
    assign word_valid = byte_valid && (lane == 2'd3);
    assign word       = {byte_data, shreg[31:8]};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length/payload/checksum frame, writes imem from word 0 and
// keeps the core in reset until a checksum-valid image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.slave      bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output state_t            dbg_state
);

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W:0]   word_cnt;
    logic [7:0]        xor_r;
    logic              xfer;
    logic              pk_valid;
    logic              word_valid;
    logic [31:0]       word;
    logic              last_word;

    assign bus.in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                          (state == LOAD)   || (state == CSUM);
    assign xfer     = bus.in_valid && bus.in_ready;
    assign pk_valid = xfer && (state == LOAD);
    assign len_full = {bus.in_data, len[7:0]};
    // word_cnt has one spare bit so it can reach DEPTH without wrapping.
    assign last_word = (LEN_W'(word_cnt) + LEN_W'(1)) == len;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (pk_valid),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            LEN_LO: if (xfer) state_nxt = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (len_full > LEN_W'(DEPTH))    state_nxt = ERR;
                    else if (len_full == '0)         state_nxt = CSUM;
                    else                             state_nxt = LOAD;
                end
            end
            LOAD:   if (word_valid && last_word) state_nxt = CSUM;
            CSUM: begin
                if (xfer) state_nxt = (bus.in_data == xor_r) ? DONE : ERR;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LEN_LO;
            len       <= '0;
            word_cnt  <= '0;
            xor_r     <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            state  <= state_nxt;
            mem_we <= word_valid;
            if (xfer && (state != CSUM)) xor_r <= xor_r ^ bus.in_data;
            if (xfer && (state == LEN_LO)) len[7:0] <= bus.in_data;
            if (xfer && (state == LEN_HI)) len <= len_full;
            if (word_valid) begin
                mem_addr  <= word_cnt[ADDR_W-1:0];
                mem_wdata <= word;
                word_cnt  <= word_cnt + (ADDR_W+1)'(1);
            end
        end
    end

    assign done       = (state == DONE);
    assign error      = (state == ERR);
    assign core_reset = (state != DONE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames driven byte by byte, imem writes scored
// against an expected queue filled from the bench's own payload model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int EW     = ADDR_W + 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;
    state_t            dbg_state;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    logic [EW-1:0]     exp_q[$];
    logic [31:0]       payload [0:DEPTH];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_writes = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    // Scoreboard: every imem write is popped against the expected queue.
    always @(negedge clk) begin
        logic [EW-1:0] exp;
        if (reset === 1'b0 && mem_we === 1'b1) begin
            n_writes++;
            last_addr = mem_addr;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%0d data=%h required=no write", mem_addr, mem_wdata);
            end else begin
                exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== exp) begin
                    n_fail++;
                    $display("FAIL write_data addr=%0d data=%h required addr=%0d data=%h",
                             mem_addr, mem_wdata, exp[EW-1:32], exp[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int waited = 0;
        int gap    = 0;
        if (max_gap > 0) gap = $urandom_range(max_gap, 0);
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
        end else begin
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] csum_flip, input int max_gap);
        logic [15:0] l16;
        logic [7:0]  x;
        logic [7:0]  b;
        l16 = len[15:0];
        x   = l16[7:0] ^ l16[15:8];
        send_byte(l16[7:0], max_gap);
        send_byte(l16[15:8], max_gap);
        for (int k = 0; k < len; k++) begin
            exp_q.push_back({ADDR_W'(k), payload[k]});
            for (int j = 0; j < 4; j++) begin
                b = payload[k][8*j +: 8];
                x = x ^ b;
                send_byte(b, max_gap);
            end
        end
        send_byte(x ^ csum_flip, max_gap);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 8;
        if (dbg_state !== LEN_LO) begin n_fail++; $display("FAIL rst_state state=%0d required=%0d", dbg_state, LEN_LO); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b required=1", bus.in_ready); end
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%b required=0", mem_we); end
        if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr got=%0d required=0", mem_addr); end
        if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_mem_wdata got=%h required=0", mem_wdata); end
        if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset got=%b required=1", core_reset); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b required=0", done); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error got=%b required=0", error); end
    endtask

    task automatic test_basic();
        logic [7:0] fr [10];
        logic [7:0] x;
        int         w0;
        do_reset();
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
        exp_q.push_back({ADDR_W'(0), 32'h0000_0013});
        exp_q.push_back({ADDR_W'(1), 32'h0050_0093});
        w0 = n_writes;
        x  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            x = x ^ fr[i];
            send_byte(fr[i], 0);
            if (i == 5) begin
                n_checks += 3;
                if (mem_we !== 1'b1) begin n_fail++; $display("FAIL basic_latency_we got=%b required=1", mem_we); end
                if (mem_addr !== '0) begin n_fail++; $display("FAIL basic_latency_addr got=%0d required=0", mem_addr); end
                if (mem_wdata !== 32'h13) begin n_fail++; $display("FAIL basic_latency_data got=%h required=00000013", mem_wdata); end
            end
            if (i == 6) begin
                n_checks++;
                if (mem_we !== 1'b0) begin n_fail++; $display("FAIL basic_we_pulse got=%b required=0", mem_we); end
            end
        end
        send_byte(x, 0);
        n_checks += 3;
        if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b required=1", done); end
        if (core_reset !== 1'b0) begin n_fail++; $display("FAIL basic_core_reset got=%b required=0", core_reset); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error got=%b required=0", error); end
        repeat (3) tick();
        n_checks += 2;
        if (n_writes - w0 != 2) begin n_fail++; $display("FAIL basic_write_count got=%0d required=2", n_writes - w0); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_len_zero();
        int w0;
        do_reset();
        w0 = n_writes;
        send_frame(0, 8'h00, 0);
        n_checks += 3;
        if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got=%b required=1", done); end
        if (core_reset !== 1'b0) begin n_fail++; $display("FAIL zero_core_reset got=%b required=0", core_reset); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready got=%b required=0", bus.in_ready); end
        repeat (3) tick();
        n_checks++;
        if (n_writes != w0) begin n_fail++; $display("FAIL zero_write_count got=%0d required=0", n_writes - w0); end
    endtask

    task automatic test_bad_csum();
        int w0;
        do_reset();
        w0 = n_writes;
        payload[0] = $urandom;
        send_frame(1, 8'h01, 0);
        n_checks += 4;
        if (error !== 1'b1) begin n_fail++; $display("FAIL badcs_error got=%b required=1", error); end
        if (core_reset !== 1'b1) begin n_fail++; $display("FAIL badcs_core_reset got=%b required=1", core_reset); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL badcs_in_ready got=%b required=0", bus.in_ready); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL badcs_done got=%b required=0", done); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        n_checks += 3;
        if (error !== 1'b1) begin n_fail++; $display("FAIL badcs_sticky got=%b required=1", error); end
        if (n_writes - w0 != 1) begin n_fail++; $display("FAIL badcs_write_count got=%0d required=1", n_writes - w0); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL badcs_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        int w0;
        logic [15:0] l16;
        do_reset();
        w0  = n_writes;
        l16 = 16'(DEPTH + 1);
        send_byte(l16[7:0], 0);
        send_byte(l16[15:8], 0);
        n_checks += 4;
        if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_error got=%b required=1", error); end
        if (dbg_state !== ERR) begin n_fail++; $display("FAIL ovf_state got=%0d required=%0d", dbg_state, ERR); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_in_ready got=%b required=0", bus.in_ready); end
        if (core_reset !== 1'b1) begin n_fail++; $display("FAIL ovf_core_reset got=%b required=1", core_reset); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        repeat (6) tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (n_writes != w0) begin n_fail++; $display("FAIL ovf_write_count got=%0d required=0", n_writes - w0); end
    endtask

    task automatic test_full_depth();
        int w0;
        do_reset();
        w0 = n_writes;
        for (int k = 0; k < DEPTH; k++) payload[k] = $urandom;
        send_frame(DEPTH, 8'h00, 3);
        n_checks += 2;
        if (done !== 1'b1) begin n_fail++; $display("FAIL full_done got=%b required=1", done); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL full_error got=%b required=0", error); end
        repeat (3) tick();
        n_checks += 3;
        if (n_writes - w0 != DEPTH) begin n_fail++; $display("FAIL full_write_count got=%0d required=%0d", n_writes - w0, DEPTH); end
        if (last_addr !== ADDR_W'(DEPTH - 1)) begin n_fail++; $display("FAIL full_last_addr got=%0d required=%0d", last_addr, DEPTH - 1); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        int w0;
        do_reset();
        w0 = n_writes;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks += 2;
        if (dbg_state !== LEN_LO) begin n_fail++; $display("FAIL midrst_state got=%0d required=%0d", dbg_state, LEN_LO); end
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_we got=%b required=0", mem_we); end
        payload[0] = $urandom;
        send_frame(1, 8'h00, 1);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_done got=%b required=1", done); end
        repeat (3) tick();
        n_checks += 3;
        if (n_writes - w0 != 1) begin n_fail++; $display("FAIL midrst_write_count got=%0d required=1", n_writes - w0); end
        if (last_addr !== '0) begin n_fail++; $display("FAIL midrst_addr got=%0d required=0", last_addr); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_pending got=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_basic();
        test_len_zero();
        test_bad_csum();
        test_overflow();
        test_full_depth();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
